// File: rtl/tx_tlp_arbiter.sv
// Packet-atomic two-source TX TLP arbiter merging an AFU and a management stream.
// Define TX_ARB_STRICT_PRIO_EN for fixed management-first priority in IDLE (round robin otherwise).
module tx_tlp_arbiter #(
   parameter int unsigned NUM_CH = 2,
   parameter int unsigned DATA_W = 256,
   parameter int unsigned USER_W = 10
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       s0_tvalid,
   output logic                       s0_tready,
   input  logic [NUM_CH-1:0]          s0_valid,
   input  logic [NUM_CH-1:0]          s0_sop,
   input  logic [NUM_CH-1:0]          s0_eop,
   input  logic [NUM_CH*DATA_W-1:0]   s0_tdata,
   input  logic [NUM_CH*USER_W-1:0]   s0_tuser,
   input  logic                       s1_tvalid,
   output logic                       s1_tready,
   input  logic [NUM_CH-1:0]          s1_valid,
   input  logic [NUM_CH-1:0]          s1_sop,
   input  logic [NUM_CH-1:0]          s1_eop,
   input  logic [NUM_CH*DATA_W-1:0]   s1_tdata,
   input  logic [NUM_CH*USER_W-1:0]   s1_tuser,
   output logic                       m_tvalid,
   output logic [NUM_CH-1:0]          m_valid,
   output logic [NUM_CH-1:0]          m_sop,
   output logic [NUM_CH-1:0]          m_eop,
   output logic [NUM_CH*DATA_W-1:0]   m_tdata,
   output logic [NUM_CH*USER_W-1:0]   m_tuser,
   input  logic                       m_tready,
   output logic                       o_grant,
   output logic                       o_locked
);

   localparam int unsigned TD_W = NUM_CH * DATA_W;
   localparam int unsigned TU_W = NUM_CH * USER_W;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] LOCK0 = 2'd1;
   localparam logic [1:0] LOCK1 = 2'd2;

   logic [1:0]        state;
   logic [1:0]        state_nxt;
   logic              rr_last;
   logic              rr_nxt;
   logic              grant_nxt;
   logic              out_ready;
   logic              req0;
   logic              req1;
   logic              acc;
   logic              acc_beat;
   logic              sel_open;
   logic [NUM_CH-1:0] sel_valid;
   logic [NUM_CH-1:0] sel_sop;
   logic [NUM_CH-1:0] sel_eop;
   logic [TD_W-1:0]   sel_tdata;
   logic [TU_W-1:0]   sel_tuser;

   // A beat ends open when its highest-index valid channel carries no eop.
   function automatic logic ends_open(input logic [NUM_CH-1:0] v, input logic [NUM_CH-1:0] e);
      logic open_f;
      open_f = 1'b0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
         if (v[i]) open_f = ~e[i];
      end
      return open_f;
   endfunction

   assign out_ready = ~m_tvalid | m_tready;
   assign s0_tready = out_ready & ~o_grant & rst_n;
   assign s1_tready = out_ready &  o_grant & rst_n;

   assign req0 = s0_tvalid & (|s0_valid);
   assign req1 = s1_tvalid & (|s1_valid);

   assign acc       = o_grant ? (s1_tvalid & s1_tready) : (s0_tvalid & s0_tready);
   assign sel_valid = o_grant ? s1_valid : s0_valid;
   assign sel_sop   = o_grant ? s1_sop   : s0_sop;
   assign sel_eop   = o_grant ? s1_eop   : s0_eop;
   assign sel_tdata = o_grant ? s1_tdata : s0_tdata;
   assign sel_tuser = o_grant ? s1_tuser : s0_tuser;

   // Empty beats are consumed from the source but never reach the output or the FSM.
   assign acc_beat = acc & (|sel_valid);
   assign sel_open = ends_open(sel_valid, sel_eop);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         rr_last  <= 1'b1;
         o_grant  <= 1'b0;
         o_locked <= 1'b0;
      end else begin
         state    <= state_nxt;
         rr_last  <= rr_nxt;
         o_grant  <= grant_nxt;
         o_locked <= (state_nxt != IDLE);
      end
   end

   // Next state, round-robin pointer and the grant seen by the next cycle.
   always_comb begin
      state_nxt = state;
      rr_nxt    = rr_last;
      grant_nxt = o_grant;
      case (state)
         IDLE: begin
            if (acc_beat) begin
               if (sel_open) state_nxt = o_grant ? LOCK1 : LOCK0;
               else          rr_nxt    = o_grant;
            end
         end
         LOCK0, LOCK1: begin
            if (acc_beat && !sel_open) begin
               state_nxt = IDLE;
               rr_nxt    = o_grant;
            end
         end
         default: state_nxt = IDLE;
      endcase

      if (state_nxt == LOCK0) begin
         grant_nxt = 1'b0;
      end else if (state_nxt == LOCK1) begin
         grant_nxt = 1'b1;
      end else begin
`ifdef TX_ARB_STRICT_PRIO_EN
         if (req1)      grant_nxt = 1'b1;
         else if (req0) grant_nxt = 1'b0;
`else
         if (req0 && req1) grant_nxt = ~rr_nxt;
         else if (req0)    grant_nxt = 1'b0;
         else if (req1)    grant_nxt = 1'b1;
`endif
      end
   end

   // Output control register: loads only while the downstream can take a beat.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         m_tvalid <= 1'b0;
         m_valid  <= '0;
         m_sop    <= '0;
         m_eop    <= '0;
      end else if (out_ready) begin
         m_tvalid <= acc_beat;
         m_valid  <= acc_beat ? sel_valid : '0;
         m_sop    <= acc_beat ? sel_sop   : '0;
         m_eop    <= acc_beat ? sel_eop   : '0;
      end
   end

   // Payload register needs no reset; it is qualified by m_tvalid.
   always_ff @(posedge clk) begin
      if (out_ready && acc_beat) begin
         m_tdata <= sel_tdata;
         m_tuser <= sel_tuser;
      end
   end

endmodule

// File: tb/tb_tx_tlp_arbiter.sv
// Self-checking bench for tx_tlp_arbiter: directed literal checks plus randomized
// traffic compared each cycle against a transaction-level model of the arbiter.
module tb_tx_tlp_arbiter;

   localparam int TDW = 512;
   localparam int TUW = 20;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            m_tready;
   logic            tv [2];
   logic [1:0]      v  [2];
   logic [1:0]      sp [2];
   logic [1:0]      ep [2];
   logic [TDW-1:0]  d  [2];
   logic [TUW-1:0]  u  [2];
   logic            in_tlp [2];
   logic            rdy0, rdy1;
   logic            m_tvalid;
   logic [1:0]      m_valid, m_sop, m_eop;
   logic [TDW-1:0]  m_tdata;
   logic [TUW-1:0]  m_tuser;
   logic            o_grant, o_locked;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   tx_tlp_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .s0_tvalid(tv[0]), .s0_tready(rdy0), .s0_valid(v[0]), .s0_sop(sp[0]), .s0_eop(ep[0]),
      .s0_tdata(d[0]), .s0_tuser(u[0]),
      .s1_tvalid(tv[1]), .s1_tready(rdy1), .s1_valid(v[1]), .s1_sop(sp[1]), .s1_eop(ep[1]),
      .s1_tdata(d[1]), .s1_tuser(u[1]),
      .m_tvalid(m_tvalid), .m_valid(m_valid), .m_sop(m_sop), .m_eop(m_eop),
      .m_tdata(m_tdata), .m_tuser(m_tuser), .m_tready(m_tready),
      .o_grant(o_grant), .o_locked(o_locked)
   );

   task automatic chk(input string name, input logic [TDW-1:0] act, input logic [TDW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // TLP still open after this beat: look at the last valid channel's eop.
   function automatic logic beat_open(input logic [1:0] vv, input logic [1:0] ee);
      if (vv[1]) return !ee[1];
      return !ee[0];
   endfunction

   // Random beat for source s that respects TLP framing across beats.
   task automatic gen_beat(input int s);
      int nv;
      v[s] = 2'b00; sp[s] = 2'b00; ep[s] = 2'b00;
      if ($urandom_range(0, 15) != 0) begin
         nv = ($urandom_range(0, 2) == 0) ? 1 : 2;
         for (int ch = 0; ch < nv; ch++) begin
            v[s][ch]  = 1'b1;
            sp[s][ch] = !in_tlp[s];
            in_tlp[s] = 1'b1;
            ep[s][ch] = ($urandom_range(0, 2) == 0);
            if (ep[s][ch]) in_tlp[s] = 1'b0;
         end
      end
      for (int w = 0; w < TDW / 32; w++) d[s][w*32 +: 32] = $urandom();
      u[s] = TUW'($urandom());
   endtask

   // Transaction-level model: predicted register contents after each clock edge.
   logic           mdl_tv;
   logic [1:0]     mdl_valid, mdl_sop, mdl_eop;
   logic [TDW-1:0] mdl_d;
   logic [TUW-1:0] mdl_u;
   int             mdl_grant, mdl_open, mdl_rr;

   initial begin : model
      int   g;
      logic ready, acc, er0, er1, req0, req1;
      mdl_tv = 1'b0; mdl_valid = 2'b00; mdl_sop = 2'b00; mdl_eop = 2'b00;
      mdl_d = '0; mdl_u = '0; mdl_grant = 0; mdl_open = -1; mdl_rr = 1;
      @(posedge clk);
      forever begin
         @(negedge clk);
         ready = !mdl_tv || m_tready;
         er0 = rst_n && ready && (mdl_grant == 0);
         er1 = rst_n && ready && (mdl_grant == 1);
         chk("mdl_tvalid", TDW'(m_tvalid), TDW'(mdl_tv));
         chk("mdl_valid",  TDW'(m_valid),  TDW'(mdl_valid));
         chk("mdl_sop",    TDW'(m_sop),    TDW'(mdl_sop));
         chk("mdl_eop",    TDW'(m_eop),    TDW'(mdl_eop));
         chk("mdl_grant",  TDW'(o_grant),  TDW'(mdl_grant));
         chk("mdl_locked", TDW'(o_locked), TDW'(mdl_open >= 0));
         chk("mdl_tready0", TDW'(rdy0), TDW'(er0));
         chk("mdl_tready1", TDW'(rdy1), TDW'(er1));
         if (mdl_tv) begin
            chk("mdl_tdata", m_tdata, mdl_d);
            chk("mdl_tuser", TDW'(m_tuser), TDW'(mdl_u));
         end
         if (!rst_n) begin
            mdl_tv = 1'b0; mdl_valid = 2'b00; mdl_sop = 2'b00; mdl_eop = 2'b00;
            mdl_grant = 0; mdl_open = -1; mdl_rr = 1;
         end else begin
            g   = mdl_grant;
            acc = tv[g] && ready;
            if (ready) begin
               mdl_tv    = acc && (v[g] != 2'b00);
               mdl_valid = mdl_tv ? v[g]  : 2'b00;
               mdl_sop   = mdl_tv ? sp[g] : 2'b00;
               mdl_eop   = mdl_tv ? ep[g] : 2'b00;
               if (mdl_tv) begin
                  mdl_d = d[g];
                  mdl_u = u[g];
               end
            end
            if (acc && (v[g] != 2'b00)) begin
               if (beat_open(v[g], ep[g])) mdl_open = g;
               else begin
                  mdl_open = -1;
                  mdl_rr   = g;
               end
            end
            req0 = tv[0] && (v[0] != 2'b00);
            req1 = tv[1] && (v[1] != 2'b00);
            if (mdl_open >= 0) mdl_grant = mdl_open;
`ifdef TX_ARB_STRICT_PRIO_EN
            else if (req1) mdl_grant = 1;
            else if (req0) mdl_grant = 0;
`else
            else if (req0 && req1) mdl_grant = 1 - mdl_rr;
            else if (req0) mdl_grant = 0;
            else if (req1) mdl_grant = 1;
`endif
         end
      end
   end

   initial begin : stim
      logic acc [2];
      int   served [2];
      int   hold;
      int   exp_src;
      logic ok;
      served[0] = 0; served[1] = 0; hold = 0;
      rst_n = 1'b0; m_tready = 1'b1;
      for (int s = 0; s < 2; s++) begin
         tv[s] = 1'b0; v[s] = 2'b00; sp[s] = 2'b00; ep[s] = 2'b00;
         d[s] = '0; u[s] = '0; in_tlp[s] = 1'b0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_tready0", TDW'(rdy0), TDW'(0));
      chk("rst_tready1", TDW'(rdy1), TDW'(0));
      chk("rst_tvalid", TDW'(m_tvalid), TDW'(0));

      // Single-beat TLP from src0 right after reset.
      @(posedge clk); #1;
      rst_n = 1'b1;
      tv[0] = 1'b1; v[0] = 2'b01; sp[0] = 2'b01; ep[0] = 2'b01; u[0] = TUW'(0);
      d[0] = {16{32'hA5A5_0001}};
      @(negedge clk);
      chk("rst_grant", TDW'(o_grant), TDW'(0));
      chk("rst_locked", TDW'(o_locked), TDW'(0));
      chk("rst_mvalid", TDW'(m_valid), TDW'(0));
      chk("single_ready", TDW'(rdy0), TDW'(1));
      @(posedge clk); #1;
      tv[0] = 1'b0;
      @(negedge clk);
      chk("single_tvalid", TDW'(m_tvalid), TDW'(1));
      chk("single_mvalid", TDW'(m_valid), TDW'(2'b01));
      chk("single_data", m_tdata, {16{32'hA5A5_0001}});
      chk("single_grant", TDW'(o_grant), TDW'(0));
      chk("single_locked", TDW'(o_locked), TDW'(0));

      // Both sources offer 1-beat TLPs every cycle.
      @(posedge clk); #1;
      for (int s = 0; s < 2; s++) begin
         tv[s] = 1'b1; v[s] = 2'b01; sp[s] = 2'b01; ep[s] = 2'b01; u[s] = TUW'(s);
      end
      for (int k = 0; k < 8; k++) begin
         @(posedge clk);
         @(negedge clk);
`ifdef TX_ARB_STRICT_PRIO_EN
         exp_src = (k == 0) ? 0 : 1;
`else
         exp_src = k % 2;
`endif
         chk("alt_tvalid", TDW'(m_tvalid), TDW'(1));
         chk("alt_source", TDW'(m_tuser[0]), TDW'(exp_src));
      end
      @(posedge clk); #1;
      tv[0] = 1'b0; tv[1] = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // 3-beat TLP from src0 with src1 contending from beat 2 onward.
      tv[0] = 1'b1; v[0] = 2'b11; sp[0] = 2'b01; ep[0] = 2'b00;
      ok = 1'b0;
      for (int i = 0; i < 10 && !ok; i++) begin
         @(negedge clk);
         if (rdy0) ok = 1'b1;
         else begin
            @(posedge clk); #1;
         end
      end
      chk("lock_wait_grant", TDW'(ok), TDW'(1));
      @(posedge clk); #1;
      v[0] = 2'b11; sp[0] = 2'b00; ep[0] = 2'b00;
      tv[1] = 1'b1; v[1] = 2'b01; sp[1] = 2'b01; ep[1] = 2'b01; u[1] = TUW'(1);
      @(negedge clk);
      chk("lock_b1_locked", TDW'(o_locked), TDW'(1));
      chk("lock_b1_block", TDW'(rdy1), TDW'(0));
      chk("lock_b1_ready0", TDW'(rdy0), TDW'(1));
      @(posedge clk); #1;
      v[0] = 2'b01; sp[0] = 2'b00; ep[0] = 2'b01;
      @(negedge clk);
      chk("lock_b2_locked", TDW'(o_locked), TDW'(1));
      chk("lock_b2_block", TDW'(rdy1), TDW'(0));
      @(posedge clk); #1;
      tv[0] = 1'b0;
      @(negedge clk);
      chk("lock_end_locked", TDW'(o_locked), TDW'(0));
      chk("lock_end_grant", TDW'(o_grant), TDW'(1));
      chk("lock_end_ready1", TDW'(rdy1), TDW'(1));
      @(posedge clk); #1;
      tv[1] = 1'b0;
      @(negedge clk);
      chk("lock_next_tvalid", TDW'(m_tvalid), TDW'(1));
      chk("lock_next_source", TDW'(m_tuser[0]), TDW'(1));
      @(posedge clk); #1;

      // Randomized traffic, back-pressure bursts and a reset mid-packet.
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         acc[0] = tv[0] && rdy0;
         acc[1] = tv[1] && rdy1;
         for (int s = 0; s < 2; s++) if (acc[s] && (v[s] != 2'b00)) served[s]++;
         @(posedge clk); #1;
         if (cyc == 1500) begin
            rst_n = 1'b0;
            for (int s = 0; s < 2; s++) begin
               tv[s] = 1'b0; in_tlp[s] = 1'b0;
            end
         end else if (cyc == 1503) begin
            rst_n = 1'b1;
         end
         if (hold > 0) begin
            m_tready = 1'b0;
            hold--;
         end else if (cyc % 200 == 100) begin
            m_tready = 1'b0;
            hold = 3;
         end else begin
            m_tready = ($urandom_range(0, 3) != 0);
         end
         if (rst_n) begin
            for (int s = 0; s < 2; s++) begin
               if (!(tv[s] && !acc[s])) begin
                  if ($urandom_range(0, 99) < 70) begin
                     tv[s] = 1'b1;
                     gen_beat(s);
                  end else begin
                     tv[s] = 1'b0;
                  end
               end
            end
         end
      end
      tv[0] = 1'b0; tv[1] = 1'b0; m_tready = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("rand_src0_served", TDW'(served[0] > 0), TDW'(1));
      chk("rand_src1_served", TDW'(served[1] > 0), TDW'(1));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
